weight_fetcher: RTL
===================

// Module: weight_fetcher
// PURPOSE
// - Initiator/CPU-side master for weight_medium's request port. Streams a run of consecutive
//   weight words to a compute consumer over valid/ready.
// - Given base address and count, issues one read per word, waits for finished, registers the word.
// - Sits between the layer sequencer (start/done) and weight_medium (addr/read_enable/finished).
// PARAMETERS
// - ADDRS       256  weight words in medium; address = $clog2(ADDRS) bits, wraps mod ADDRS
// - BRAM_WIDTH  64   bits per BRAM piece
// - PIECES      48   pieces per word; WIDTH = PIECES*BRAM_WIDTH
// PORTS
// - clk_in            in   1               clock; single clock domain
// - rst_in            in   1               synchronous, active-high reset
// - start_in          in   1               pulse: begin run; sampled only in IDLE
// - base_addr_in      in   $clog2(ADDRS)   first word address, sampled with start_in
// - count_in          in   $clog2(ADDRS)+1 words in run (0..ADDRS), sampled with start_in
// - busy_out          out  1               high from accepted start until done_out
// - done_out          out  1               one-cycle pulse: run complete
// - weight_valid_out  out  1               weight_data_out holds a valid word
// - weight_ready_in   in   1               consumer accepts when valid&ready
// - weight_data_out   out  WIDTH           current word
// - med_addr_out      out  $clog2(ADDRS)   to medium addr_in
// - med_read_en_out   out  1               to medium read_enable; one-cycle pulse per request
// - med_write_en_out  out  1               to medium write_enable; constant 0
// - med_weight_wr_out out  WIDTH           to medium weight_in; constant 0
// - med_weight_in     in   WIDTH           from medium weight_out; valid in cycle med_finished_in=1
// - med_finished_in   in   1               from medium finished_out; one-cycle pulse per request
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, internal address/count/buffers cleared.
// - FSM states: IDLE, ISSUE, WAIT, HOLD, DONE.
// - IDLE, start_in=1, count_in>0: latch addr/count; go ISSUE; busy_out=1 next cycle.
// - IDLE, start_in=1, count_in=0: go DONE; no medium request.
// - ISSUE (1 cycle): med_read_en_out=1 with med_addr_out=cur_addr; go WAIT.
// - WAIT: hold med_addr_out.
//   - On med_finished_in: register med_weight_in into data reg; weight_valid_out=1 next cycle; go HOLD.
// - HOLD: data and valid held stable until valid&ready.
//   - On handshake, decrement remaining; addr = addr+1 mod ADDRS.
//   - If remaining was 1, go DONE; else go ISSUE.
// - DONE (1 cycle): done_out=1, busy_out=0 next cycle; return IDLE.
// - Latency: start at cycle T -> read pulse at T+1; finished at F -> valid at F+1.
//   - Handshake at H -> next read pulse at H+1 (no prefetch).
// - med_finished_in outside WAIT (or prefetch-in-flight) ignored; never updates data.
// - start_in while busy_out=1 ignored; base/count unchanged.
// - Exactly one medium request outstanding at any time; med_read_en_out never asserted in WAIT.
// - Reset mid-run: immediate IDLE, outputs 0. A late finished pulse from the aborted request
//   is ignored. The medium completes that request on its own.
// CONFIGURATION
// - WEIGHT_FETCHER_PREFETCH_EN defined: second WIDTH buffer (skid entry).
//   - In HOLD, when words remain and skid is empty, the next read issues one cycle after
//     entering HOLD; its result lands in skid.
//   - On handshake, skid moves to data reg with valid staying 1 (back-to-back beats).
//   - Still max one request outstanding.
// - Undefined: no skid buffer; next read issued only after handshake, as above.
// TESTING
// - base=5,count=3,ready=1: reads addr 5,6,7, 3 beats carry medium data in order;
//   done_out pulses once; busy low after.
// - base=ADDRS-1,count=2: med_addr_out 255 then 0; 2 beats; done_out.
// - count=0: done_out at T+2, med_read_en_out never asserted, weight_valid_out stays 0.
// - ready=0 for 10 cycles after first valid: data_out stable, valid=1.
//   - No further read without PREFETCH_EN; exactly one further read with it.
// - rst_in=1 in WAIT, then finished pulse 3 cycles later: outputs 0, IDLE, no valid beat.
// - start_in pulsed again mid-run with base=100: ignored; addresses continue original sequence.

Source files
------------

// File: rtl/weight_fetcher.sv
// weight_fetcher: streams a run of consecutive weight words from weight_medium to a valid/ready consumer.
// Define WEIGHT_FETCHER_PREFETCH_EN to add a skid buffer that fetches the next word while the current one is held.
module weight_fetcher #(
  parameter int ADDRS = 256,
  parameter int BRAM_WIDTH = 64,
  parameter int PIECES = 48,
  localparam int AW = $clog2(ADDRS),
  localparam int WIDTH = PIECES * BRAM_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [AW-1:0]    base_addr_in,
  input  logic [AW:0]      count_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             weight_valid_out,
  input  logic             weight_ready_in,
  output logic [WIDTH-1:0] weight_data_out,
  output logic [AW-1:0]    med_addr_out,
  output logic             med_read_en_out,
  output logic             med_write_en_out,
  output logic [WIDTH-1:0] med_weight_wr_out,
  input  logic [WIDTH-1:0] med_weight_in,
  input  logic             med_finished_in
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, maddr_q, maddr_d, next_addr;
  logic [AW:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, busy_q, busy_d, done_q, done_d, rd_q, rd_d, hs, last;
`ifdef WEIGHT_FETCHER_PREFETCH_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic skid_v_q, skid_v_d, pf_q, pf_d;
`endif
  assign hs = valid_q & weight_ready_in;
  assign last = rem_q == (AW+1)'(1);
  assign next_addr = (addr_q == AW'(ADDRS - 1)) ? '0 : addr_q + 1'b1;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    maddr_d = maddr_q;
    rem_d = rem_q;
    data_d = data_q;
    valid_d = valid_q;
    busy_d = busy_q;
    done_d = 1'b0;
    rd_d = 1'b0;
`ifdef WEIGHT_FETCHER_PREFETCH_EN
    skid_d = skid_q;
    skid_v_d = skid_v_q;
    pf_d = pf_q;
`endif
    case (state_q)
      IDLE: if (start_in) begin
        busy_d = 1'b1;
        state_d = |count_in ? ISSUE : DONE;
        rd_d = |count_in;
        addr_d = base_addr_in;
        maddr_d = base_addr_in;
        rem_d = count_in;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (med_finished_in) begin
        data_d = med_weight_in;
        valid_d = 1'b1;
        state_d = HOLD;
      end
`ifdef WEIGHT_FETCHER_PREFETCH_EN
      HOLD: if (hs) begin
        rem_d = rem_q - 1'b1;
        addr_d = next_addr;
        if (last) begin
          valid_d = 1'b0;
          state_d = DONE;
        end else if (skid_v_q) begin
          data_d = skid_q;
          skid_v_d = 1'b0;
        end else if (pf_q && med_finished_in) begin
          data_d = med_weight_in;
          pf_d = 1'b0;
        end else if (pf_q) begin
          // prefetch still in flight: WAIT captures it straight into the data register
          valid_d = 1'b0;
          pf_d = 1'b0;
          state_d = WAIT;
        end else begin
          valid_d = 1'b0;
          maddr_d = next_addr;
          rd_d = 1'b1;
          state_d = ISSUE;
        end
      end else if (pf_q && med_finished_in) begin
        skid_d = med_weight_in;
        skid_v_d = 1'b1;
        pf_d = 1'b0;
      end else if (!pf_q && !skid_v_q && !last) begin
        maddr_d = next_addr;
        rd_d = 1'b1;
        pf_d = 1'b1;
      end
`else
      HOLD: if (hs) begin
        valid_d = 1'b0;
        rem_d = rem_q - 1'b1;
        addr_d = next_addr;
        maddr_d = last ? maddr_q : next_addr;
        rd_d = !last;
        state_d = last ? DONE : ISSUE;
      end
`endif
      DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      addr_q <= '0;
      maddr_q <= '0;
      rem_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_q <= 1'b0;
`ifdef WEIGHT_FETCHER_PREFETCH_EN
      skid_q <= '0;
      skid_v_q <= 1'b0;
      pf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      maddr_q <= maddr_d;
      rem_q <= rem_d;
      data_q <= data_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rd_q <= rd_d;
`ifdef WEIGHT_FETCHER_PREFETCH_EN
      skid_q <= skid_d;
      skid_v_q <= skid_v_d;
      pf_q <= pf_d;
`endif
    end
  end
  assign busy_out = busy_q;
  assign done_out = done_q;
  assign weight_valid_out = valid_q;
  assign weight_data_out = data_q;
  assign med_addr_out = maddr_q;
  assign med_read_en_out = rd_q;
  assign med_write_en_out = 1'b0;
  assign med_weight_wr_out = '0;
endmodule
